// File: rtl/stereo_dematrix_48_if.sv
// Sample/gain/result bundle between a sum/difference source and the
// stereo dematrix. The source side (master) drives the two sample streams and
// the gains. The dematrix side (slave) returns the rebuilt L/R pair and status.
interface stereo_dematrix_48_if #(
    parameter int DW = 18,
    parameter int GW = 4
);
    // Sum (L+R) stream
    logic signed [DW-1:0] lpr_in;
    logic                 lpr_valid;
    // Difference (L-R) stream
    logic signed [DW-1:0] lmr_in;
    logic                 lmr_valid;
    // Per-path unsigned gains, sampled when a pair starts
    logic        [GW-1:0] Gs;
    logic        [GW-1:0] Gd;
    // Recovered stereo pair and status
    logic signed [DW-1:0] left_out;
    logic signed [DW-1:0] right_out;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        output lpr_in, lpr_valid, lmr_in, lmr_valid, Gs, Gd,
        input  left_out, right_out, out_valid, busy, overrun
    );

    modport slave (
        input  lpr_in, lpr_valid, lmr_in, lmr_valid, Gs, Gd,
        output left_out, right_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/stereo_dematrix_48.sv
// Receive-side stereo dematrix for the 48 kHz sum/difference link.
// Pairs one L+R and one L-R sample (any arrival order), scales each by its
// gain with a GW-step shift-add multiplier, applies an arithmetic right shift,
// and rebuilds saturated LEFT = s+d, RIGHT = s-d with a one-cycle strobe.
// Pairs that complete while a computation is in flight wait in one-deep
// capture registers and start as soon as the engine returns to IDLE.
module stereo_dematrix_48 #(
    parameter int DW    = 18,
    parameter int GW    = 4,
    parameter int SHIFT = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    stereo_dematrix_48_if.slave  bus
);

    // Accumulator holds sample * (2^GW - 1) without overflow.
    localparam int AW = DW + GW + 1;
    // One extra bit so s+d and s-d cannot wrap before saturation.
    localparam int SW = DW + GW + 2;
    localparam int CW = (GW > 1) ? $clog2(GW) : 1;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        SUM  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Capture side
    logic signed [DW-1:0] lpr_cap_q;
    logic signed [DW-1:0] lmr_cap_q;
    logic                 lpr_full_q;
    logic                 lmr_full_q;
    logic                 overrun_q;

    // Multiplier working set
    logic signed [AW-1:0] lpr_sh_q;
    logic signed [AW-1:0] lmr_sh_q;
    logic        [GW-1:0] gs_sh_q;
    logic        [GW-1:0] gd_sh_q;
    logic signed [AW-1:0] acc_s_q;
    logic signed [AW-1:0] acc_d_q;
    logic        [CW-1:0] step_q;

    // Result registers
    logic signed [DW-1:0] left_q;
    logic signed [DW-1:0] right_q;
    logic                 out_valid_q;

    // Combinational result path
    logic signed [AW-1:0] s_shr;
    logic signed [AW-1:0] d_shr;
    logic signed [SW-1:0] left_w;
    logic signed [SW-1:0] right_w;

    // A pair is handed to the multiplier (and the capture slots freed) on
    // any edge where the engine is idle and both slots hold a sample.
    logic start;
    assign start = (state_q == IDLE) && lpr_full_q && lmr_full_q;

    // Clamp a wide signed value into the DW-bit output range.
    function automatic logic signed [DW-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end else begin
            return v[DW-1:0];
        end
    endfunction

    // Sign-extend a DW-bit sample to accumulator width.
    function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] x);
        return {{(AW - DW){x[DW-1]}}, x};
    endfunction

    // Capture registers: a strobe always loads; a strobe into a still-full
    // slot that is not being released on this edge flags a lost sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            lpr_cap_q  <= '0;
            lmr_cap_q  <= '0;
            lpr_full_q <= 1'b0;
            lmr_full_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples the
            // pre-edge values; with = the order of these statements would
            // change the hardware.
            if (bus.lpr_valid) begin
                lpr_cap_q  <= bus.lpr_in;
                lpr_full_q <= 1'b1;
                if (lpr_full_q && !start) begin
                    overrun_q <= 1'b1;
                end
            end else if (start) begin
                lpr_full_q <= 1'b0;
            end

            if (bus.lmr_valid) begin
                lmr_cap_q  <= bus.lmr_in;
                lmr_full_q <= 1'b1;
                if (lmr_full_q && !start) begin
                    overrun_q <= 1'b1;
                end
            end else if (start) begin
                lmr_full_q <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE waits for a full pair, MULT runs GW steps, SUM
    // takes one cycle to form and register the outputs.
    always_comb begin
        // NOTE: state_d gets a default before the case so every path assigns
        // it and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MULT;
                end
            end
            MULT: begin
                if (step_q == CW'(GW - 1)) begin
                    state_d = SUM;
                end
            end
            SUM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift-add multiplier: the sample is shifted left and the gain right
    // each step, so the accumulator adds sample<<k whenever gain bit k is set.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the working set is reset along with control so that an
            // aborted computation leaves no partial product behind.
            lpr_sh_q <= '0;
            lmr_sh_q <= '0;
            gs_sh_q  <= '0;
            gd_sh_q  <= '0;
            acc_s_q  <= '0;
            acc_d_q  <= '0;
            step_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lpr_sh_q <= sext(lpr_cap_q);
                        lmr_sh_q <= sext(lmr_cap_q);
                        gs_sh_q  <= bus.Gs;
                        gd_sh_q  <= bus.Gd;
                        acc_s_q  <= '0;
                        acc_d_q  <= '0;
                        step_q   <= '0;
                    end
                end
                MULT: begin
                    if (gs_sh_q[0]) begin
                        acc_s_q <= acc_s_q + lpr_sh_q;
                    end
                    if (gd_sh_q[0]) begin
                        acc_d_q <= acc_d_q + lmr_sh_q;
                    end
                    lpr_sh_q <= lpr_sh_q <<< 1;
                    lmr_sh_q <= lmr_sh_q <<< 1;
                    gs_sh_q  <= gs_sh_q >> 1;
                    gd_sh_q  <= gd_sh_q >> 1;
                    step_q   <= step_q + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Rescale both products and form the wide sum and difference.
    always_comb begin
        s_shr   = acc_s_q >>> SHIFT;
        d_shr   = acc_d_q >>> SHIFT;
        left_w  = {s_shr[AW-1], s_shr} + {d_shr[AW-1], d_shr};
        right_w = {s_shr[AW-1], s_shr} - {d_shr[AW-1], d_shr};
    end

    // Output registers: updated only in SUM, held otherwise; the strobe is a
    // single cycle because SUM always lasts exactly one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_q == SUM);
            if (state_q == SUM) begin
                left_q  <= saturate(left_w);
                right_q <= saturate(right_w);
            end
        end
    end

    assign bus.left_out  = left_q;
    assign bus.right_out = right_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_stereo_dematrix_48.sv
// Self-checking bench for stereo_dematrix_48: directed scenarios plus a
// randomized run, all compared against a plain-arithmetic model of the
// dematrix (integer products, floor shift, clamp) and an engine-timing model.
module tb_stereo_dematrix_48;

    localparam int DW    = 18;
    localparam int GW    = 4;
    localparam int SHIFT = 3;
    localparam int LAT   = GW + 2;

    logic clock;
    logic reset;

    stereo_dematrix_48_if #(.DW(DW), .GW(GW)) bus ();

    stereo_dematrix_48 #(.DW(DW), .GW(GW), .SHIFT(SHIFT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: records every strobe with its cycle index and flags
    // strobes on two consecutive cycles.
    int obs_c[$];
    int obs_l[$];
    int obs_r[$];
    bit prev_valid = 1'b0;

    always @(negedge clock) begin
        if (bus.out_valid === 1'b1) begin
            n_vec++;
            if (prev_valid) begin
                n_err++;
                $display("FAIL double_strobe: out_valid high on consecutive cycles at cycle %0d, required single", cyc);
            end
            obs_c.push_back(cyc);
            obs_l.push_back(int'(bus.left_out));
            obs_r.push_back(int'(bus.right_out));
        end
        prev_valid = (bus.out_valid === 1'b1);
    end

    // ---------------- reference model ----------------
    function automatic int clamp(input longint v);
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    function automatic void model(input int lp, input int lm, input int gs, input int gd,
                                  output int l, output int r);
        longint s = (longint'(lp) * longint'(gs)) >>> SHIFT;
        longint d = (longint'(lm) * longint'(gd)) >>> SHIFT;
        l = clamp(s + d);
        r = clamp(s - d);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- stimulus helpers ----------------
    // All helpers start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_gains(input int gs, input int gd);
        bus.Gs = GW'(gs);
        bus.Gd = GW'(gd);
    endtask

    // Drive strobes for one cycle; e0 is the cycle index of the capture edge.
    task automatic strobe(input bit dl, input int lv, input bit dm, input int mv, output int e0);
        bus.lpr_valid = dl;
        bus.lpr_in    = DW'(lv);
        bus.lmr_valid = dm;
        bus.lmr_in    = DW'(mv);
        @(posedge clock);
        #1;
        bus.lpr_valid = 1'b0;
        bus.lmr_valid = 1'b0;
        e0 = cyc;
    endtask

    // Wait (bounded) for the next recorded output strobe.
    task automatic get_out(output bit got, output int c, output int l, output int r);
        int waited = 0;
        while (obs_c.size() == 0 && waited < 40) begin
            idle(1);
            waited++;
        end
        got = (obs_c.size() != 0);
        c = -1; l = 0; r = 0;
        if (got) begin
            c = obs_c.pop_front();
            l = obs_l.pop_front();
            r = obs_r.pop_front();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus.left_out !== '0 || bus.right_out !== '0 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got l=%0d r=%0d v=%b busy=%b ovr=%b, required all zero",
                     bus.left_out, bus.right_out, bus.out_valid, bus.busy, bus.overrun);
        end
    endtask

    task automatic test_basic();
        int e0, ec, c, l, r;
        bit got;
        set_gains(8, 8);
        strobe(1, 600, 0, 0, e0);
        idle(2);
        strobe(0, 0, 1, 400, e0);
        ec = e0 + LAT;
        get_out(got, c, l, r);
        n_vec++;
        if (!got || c !== ec || l !== 1000 || r !== 200) begin
            n_err++;
            $display("FAIL basic: got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=1000 r=200",
                     got, c, l, r, ec);
        end
        idle(8);
        n_vec++;
        if (obs_c.size() != 0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after: got extra=%0d ovr=%b busy=%b, required 0/0/0",
                     obs_c.size(), bus.overrun, bus.busy);
        end
        n_vec++;
        if (bus.left_out !== 18'sd1000 || bus.right_out !== 18'sd200) begin
            n_err++;
            $display("FAIL basic_hold: got l=%0d r=%0d, required held 1000/200", bus.left_out, bus.right_out);
        end
    endtask

    task automatic test_simultaneous();
        int e0, c, l, r;
        bit got;
        set_gains(15, 0);
        strobe(1, 600, 1, 400, e0);
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL simul_busy_e0: got busy=%b, required 0", bus.busy);
        end
        idle(1);
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL simul_busy_e1: got busy=%b, required 1", bus.busy);
        end
        get_out(got, c, l, r);
        n_vec++;
        if (!got || c !== e0 + LAT || l !== 1125 || r !== 1125) begin
            n_err++;
            $display("FAIL simultaneous: got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=1125 r=1125",
                     got, c, l, r, e0 + LAT);
        end
    endtask

    task automatic test_saturation();
        int e0, c, l, r;
        bit got;
        set_gains(8, 8);
        strobe(1, 131071, 1, 131071, e0);
        get_out(got, c, l, r);
        n_vec++;
        if (!got || c !== e0 + LAT || l !== 131071 || r !== 0) begin
            n_err++;
            $display("FAIL sat_pos: got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=131071 r=0",
                     got, c, l, r, e0 + LAT);
        end
        strobe(1, -131072, 1, 131071, e0);
        get_out(got, c, l, r);
        n_vec++;
        if (!got || c !== e0 + LAT || l !== -1 || r !== -131072) begin
            n_err++;
            $display("FAIL sat_neg: got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=-1 r=-131072",
                     got, c, l, r, e0 + LAT);
        end
    endtask

    task automatic test_back_to_back();
        int e0, e1, c1, c2, ec1, ec2, l, r;
        bit got;
        set_gains(8, 8);
        strobe(1, 600, 1, 400, e0);
        idle(2);
        strobe(1, -8, 1, 8, e1);
        ec1 = e0 + LAT;
        ec2 = max2(e1 + 1, ec1 + 1) + GW + 1;
        get_out(got, c1, l, r);
        n_vec++;
        if (!got || c1 !== ec1 || l !== 1000 || r !== 200) begin
            n_err++;
            $display("FAIL b2b_first: got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=1000 r=200",
                     got, c1, l, r, ec1);
        end
        get_out(got, c2, l, r);
        n_vec++;
        if (!got || c2 !== ec2 || l !== 0 || r !== -16) begin
            n_err++;
            $display("FAIL b2b_second: got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=0 r=-16",
                     got, c2, l, r, ec2);
        end
        n_vec++;
        if (c2 - c1 < LAT || bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_spacing: got gap=%0d ovr=%b, required gap>=%0d ovr=0", c2 - c1, bus.overrun, LAT);
        end
    endtask

    task automatic test_overrun();
        int e0, c, l, r;
        bit got;
        set_gains(8, 8);
        strobe(1, 10, 0, 0, e0);
        strobe(1, 20, 0, 0, e0);
        n_vec++;
        if (bus.overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got ovr=%b, required 1", bus.overrun);
        end
        strobe(0, 0, 1, 4, e0);
        get_out(got, c, l, r);
        n_vec++;
        if (!got || c !== e0 + LAT || l !== 24 || r !== 16) begin
            n_err++;
            $display("FAIL overrun_data: got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=24 r=16",
                     got, c, l, r, e0 + LAT);
        end
        idle(10);
        n_vec++;
        if (bus.overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: got ovr=%b, required 1", bus.overrun);
        end
        do_reset();
        n_vec++;
        if (bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: got ovr=%b, required 0 after reset", bus.overrun);
        end
    endtask

    task automatic test_reset_mid_mult();
        int e0, c, l, r;
        bit got;
        set_gains(8, 8);
        strobe(1, 600, 1, 400, e0);
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.left_out !== '0 ||
            bus.right_out !== '0 || bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: got busy=%b v=%b l=%0d r=%0d ovr=%b, required all zero",
                     bus.busy, bus.out_valid, bus.left_out, bus.right_out, bus.overrun);
        end
        idle(10);
        n_vec++;
        if (obs_c.size() != 0) begin
            n_err++;
            $display("FAIL midreset_abort: got %0d strobes after reset, required 0", obs_c.size());
            obs_c.delete(); obs_l.delete(); obs_r.delete();
        end
        strobe(1, 10, 1, 4, e0);
        get_out(got, c, l, r);
        n_vec++;
        if (!got || c !== e0 + LAT || l !== 14 || r !== 6) begin
            n_err++;
            $display("FAIL midreset_fresh: got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=14 r=6",
                     got, c, l, r, e0 + LAT);
        end
    endtask

    // Random samples, gains, arrival order and gaps; gains are disturbed
    // mid-computation, which must not affect the pair in flight.
    task automatic test_random();
        int e0, c, l, r, el, er, lp, lm, gs, gd, order, gap;
        bit got;
        for (int i = 0; i < 40; i++) begin
            lp    = int'($urandom_range(262143, 0)) - 131072;
            lm    = int'($urandom_range(262143, 0)) - 131072;
            gs    = int'($urandom_range(15, 0));
            gd    = int'($urandom_range(15, 0));
            order = int'($urandom_range(2, 0));
            gap   = int'($urandom_range(3, 0));
            if (i < 4) begin
                gs = (i % 2 == 0) ? 0 : 15;
                gd = (i < 2) ? 15 : 0;
            end
            set_gains(gs, gd);
            model(lp, lm, gs, gd, el, er);
            case (order)
                0: strobe(1, lp, 1, lm, e0);
                1: begin
                    strobe(1, lp, 0, 0, e0);
                    idle(gap);
                    strobe(0, 0, 1, lm, e0);
                end
                default: begin
                    strobe(0, 0, 1, lm, e0);
                    idle(gap);
                    strobe(1, lp, 0, 0, e0);
                end
            endcase
            idle(2);
            set_gains(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
            get_out(got, c, l, r);
            n_vec++;
            if (!got || c !== e0 + LAT || l !== el || r !== er) begin
                n_err++;
                $display("FAIL random[%0d]: lpr=%0d lmr=%0d gs=%0d gd=%0d got found=%b cyc=%0d l=%0d r=%0d, required cyc=%0d l=%0d r=%0d",
                         i, lp, lm, gs, gd, got, c, l, r, e0 + LAT, el, er);
            end
            idle(int'($urandom_range(2, 0)));
        end
        n_vec++;
        if (bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL random_overrun: got ovr=%b, required 0", bus.overrun);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.lpr_in    = '0;
        bus.lpr_valid = 1'b0;
        bus.lmr_in    = '0;
        bus.lmr_valid = 1'b0;
        bus.Gs        = '0;
        bus.Gd        = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_basic();
        test_simultaneous();
        test_saturation();
        test_back_to_back();
        test_overrun();
        test_reset_mid_mult();
        test_random();
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stereo_dematrix_48.md
Name: stereo_dematrix_48

Overview:
- Receive side of the 48 kHz sum/difference matrix.
- Accepts gain-scaled L+R and L−R sample streams, each with its own one-cycle valid strobe; the two streams may arrive in any order.
- Pairs one sample from each stream, rescales each with a 4-step sequential shift-add multiplier, and rebuilds saturated LEFT/RIGHT outputs with a one-cycle valid strobe.
- Used on the loopback/verification path and the demodulator back end.

Parameters:
- DW, 18, sample width (signed) of inputs and outputs.
- GW, 4, width of unsigned gain inputs; also the number of multiply cycles.
- SHIFT, 3, arithmetic right shift applied to each product.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- lpr_in  in  DW  signed scaled L+R sample
- lpr_valid  in  1  one-cycle strobe; lpr_in is valid on this cycle
- lmr_in  in  DW  signed scaled L−R sample
- lmr_valid  in  1  one-cycle strobe; lmr_in is valid on this cycle
- Gs  in  GW  unsigned sum-path gain
- Gd  in  GW  unsigned difference-path gain
- left_out  out  DW  signed recovered left sample
- right_out  out  DW  signed recovered right sample
- out_valid  out  1  one-cycle strobe; outputs are updated on this cycle
- busy  out  1  high when FSM is in MULT or SUM
- overrun  out  1  sticky; a captured sample was overwritten before use

Behaviour:
- Reset (synchronous, highest priority):
  - left_out=0, right_out=0, out_valid=0, busy=0, overrun=0.
  - Both capture registers empty; FSM=IDLE; accumulators=0.
  - Reset mid-operation aborts the computation; no out_valid follows.
- Capture:
  - Each stream has a one-deep capture register and a full flag.
  - A strobe loads the register and sets its full flag.
  - A strobe on an already-full register overwrites it and sets overrun. Exception: no overrun if that register is being released on the same edge.
  - Both strobes on the same cycle: both are captured; the pair completes on that edge.
- FSM states: IDLE, MULT, SUM.
  - IDLE→MULT when both full flags are set. On this edge:
    - copy both samples into working registers;
    - sample Gs/Gd into shift registers;
    - clear the accumulators and step counter;
    - clear both full flags, which frees the capture registers for the next pair.
  - MULT, GW cycles, step k=0..GW−1 (both paths in parallel): if gain bit k is set, acc += sample<<k (sign-extended, DW+GW+1 bits).
  - MULT→SUM after step GW−1.
  - SUM, 1 cycle:
    - s = acc_s>>>SHIFT; d = acc_d>>>SHIFT;
    - left = s+d; right = s−d, computed at DW+GW+2 bits;
    - saturate each to [−2^(DW−1), 2^(DW−1)−1];
    - register to left_out/right_out and pulse out_valid.
  - SUM→IDLE.
- Latency: the completing strobe is sampled at edge E0; out_valid is high for exactly the cycle after edge E0+GW+2 (E0+6 at default GW).
- Pairs completing while busy wait in the capture registers and start on the first edge with FSM=IDLE. Minimum output spacing is GW+2 cycles.
- Outputs hold their values between strobes. out_valid is never high on two consecutive cycles.
- Gain value 0 gives zero on that path. Gains change only between pairs; a change during MULT has no effect until the next pair.
- busy = (state != IDLE).

Test Plan:
- Basic: lpr=600 on cycle 0, lmr=400 on cycle 3, Gs=Gd=8 → one out_valid 6 cycles after the lmr strobe edge, with left=1000, right=200.
- Simultaneous strobes and gain shaping: lpr=600, lmr=400 on the same cycle, Gs=15, Gd=0 → left=right=1125.
- Saturation:
  - lpr=131071, lmr=131071, G=8/8 → left=131071 (clamped), right=0.
  - lpr=−131072, lmr=131071 → left=−1, right=−131072.
- Overrun: lpr=10 then lpr=20 before any lmr, then lmr=4, G=8/8 → overrun=1; output left=24, right=16; overrun stays 1 until reset.
- Back-to-back pairs: second pair (lpr=−8, lmr=8) arrives 2 cycles into the first pair's MULT → both pairs produce outputs, overrun=0. Second out_valid is at least 6 cycles after the first; second outputs are left=0, right=−16.
- Reset mid-MULT: assert reset for 1 cycle at step 2 → no out_valid; all outputs 0, busy=0. A fresh pair afterwards computes normally.
